param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 105 ++++++++++
 tb/tb_param_sync_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, level flags and sticky over/underflow flags.
// FWFT selects a combinational head-of-queue output or a registered read port.
module param_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned AF_LVL = 12,
  parameter int unsigned AE_LVL = 4,
  parameter bit          FWFT   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AfLvl    = (ADDR_W + 1)'(AF_LVL);
  localparam logic [ADDR_W:0] AeLvl    = (ADDR_W + 1)'(AE_LVL);

  logic [DATA_W-1:0] mem_q [Depth];
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;

  // Count falls out of the modulo pointer difference; the wrap bit disambiguates full/empty.
  assign count        = wptr_q - rptr_q;
  assign full         = (count == DepthCnt);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AfLvl);
  assign almost_empty = (count <= AeLvl);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;
    // A rejected access in the same cycle as clr_err wins.
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end
    if (rd_en && empty) begin
      underflow_d = 1'b1;
    end else if (clr_err) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= data_in;
    end
  end

  if (FWFT) begin : g_fwft
    assign data_out = mem_q[rptr_q[ADDR_W-1:0]];
  end else begin : g_reg
    logic [DATA_W-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= mem_q[rptr_q[ADDR_W-1:0]];
      end
    end
    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: a FWFT and a registered-output FIFO share stimulus and are
// compared against a queue-based reference model, a vector table and directed sequences.
module tb_param_sync_fifo;

  localparam int Depth = 16;
  localparam int AfLvl = 12;
  localparam int AeLvl = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] dout1, dout0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic [4:0] cnt1, cnt0;

  always #5 clk = ~clk;

  param_sync_fifo #(.FWFT(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .clr_err(clr_err), .data_out(dout1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1), .overflow(ovf1),
    .underflow(unf1)
  );

  param_sync_fifo #(.FWFT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .clr_err(clr_err), .data_out(dout0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0), .overflow(ovf0),
    .underflow(unf0)
  );

  int total = 0;
  int bad = 0;

  // Reference model: a plain queue plus sticky flags and the registered read word.
  logic [7:0] mq[$];
  bit         m_ovf, m_unf;
  logic [7:0] m_dreg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit w, input logic [7:0] d, input bit r, input bit c,
                            input bit rs);
    bit wa, ra;
    if (rs) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_dreg = 8'h00;
    end else begin
      wa = w && (mq.size() < Depth);
      ra = r && (mq.size() > 0);
      if (w && !wa) m_ovf = 1'b1;
      else if (c)   m_ovf = 1'b0;
      if (r && !ra) m_unf = 1'b1;
      else if (c)   m_unf = 1'b0;
      if (ra) m_dreg = mq.pop_front();
      if (wa) mq.push_back(d);
    end
  endtask

  task automatic model_check();
    int n;
    n = mq.size();
    chk("count", 32'(cnt1), 32'(n));
    chk("full", 32'(full1), 32'(n == Depth));
    chk("empty", 32'(empty1), 32'(n == 0));
    chk("almost_full", 32'(af1), 32'(n >= AfLvl));
    chk("almost_empty", 32'(ae1), 32'(n <= AeLvl));
    chk("overflow", 32'(ovf1), 32'(m_ovf));
    chk("underflow", 32'(unf1), 32'(m_unf));
    if (n > 0) chk("fwft_head", 32'(dout1), 32'(mq[0]));
    chk("reg_count", 32'(cnt0), 32'(n));
    chk("reg_flags", {28'd0, full0, empty0, ovf0, unf0},
        {28'd0, n == Depth, n == 0, m_ovf, m_unf});
    chk("reg_levels", {30'd0, af0, ae0}, {30'd0, n >= AfLvl, n <= AeLvl});
    chk("reg_dout", 32'(dout0), 32'(m_dreg));
  endtask

  task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit c, input bit rs);
    wr_en = w; data_in = d; rd_en = r; clr_err = c; rst = rs;
    @(posedge clk);
    model_step(w, d, r, c, rs);
    #1;
    model_check();
  endtask

  typedef struct {
    bit         w;
    logic [7:0] d;
    bit         r;
    bit         c;
    bit         rs;
    int         cnt;
    bit         emp;
    bit         ovf;
    bit         unf;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // w, d, r, clr, rst -> count, empty, overflow, underflow
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'hD4, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 8'hE5, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0});

    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c, tbl[i].rs);
      chk("tbl_count", 32'(cnt1), 32'(tbl[i].cnt));
      chk("tbl_empty", 32'(empty1), 32'(tbl[i].emp));
      chk("tbl_overflow", 32'(ovf1), 32'(tbl[i].ovf));
      chk("tbl_underflow", 32'(unf1), 32'(tbl[i].unf));
    end

    // Fill 0x01..0x10, then one write too many.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0);
      chk("fill_af", 32'(af1), 32'(i + 1 >= 12));
    end
    chk("fill_full", 32'(full1), 32'd1);
    chk("fill_count", 32'(cnt1), 32'd16);
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf1), 32'd1);
    chk("ovf_count", 32'(cnt1), 32'd16);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ovf_clr", 32'(ovf1), 32'd0);

    // Drain and check order on both output styles.
    for (int i = 0; i < 16; i++) begin
      chk("drain_fwft", 32'(dout1), 32'(i + 1));
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("drain_reg", 32'(dout0), 32'(i + 1));
    end
    chk("drain_empty", 32'(empty1), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("unf_set", 32'(unf1), 32'd1);
    chk("unf_count", 32'(cnt1), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Simultaneous read/write at full, then at half full.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    chk("full_rw_count", 32'(cnt1), 32'd15);
    chk("full_rw_ovf", 32'(ovf1), 32'd1);
    chk("full_rw_dout", 32'(dout0), 32'h20);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'hEF, 1'b1, 1'b0, 1'b0);
    chk("half_rw_count", 32'(cnt1), 32'd8);
    chk("half_rw_ovf", 32'(ovf1), 32'd0);

    // Interleaved traffic across the pointer wrap.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 40; j++) begin
      chk("wrap_fwft", 32'(dout1), 32'(8'h40 + j));
      cyc(1'b1, 8'(8'h42 + j), 1'b1, 1'b0, 1'b0);
      chk("wrap_reg", 32'(dout0), 32'(8'h40 + j));
      chk("wrap_count", 32'(cnt1), 32'd2);
    end

    // Registered read latency.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("reg_before_rd", 32'(dout0), 32'h00);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("reg_after_rd", 32'(dout0), 32'hA5);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reg_hold", 32'(dout0), 32'hA5);

    // Reset with count=7 and overflow set, then reuse.
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(cnt1), 32'd7);
    chk("pre_rst_ovf", 32'(ovf1), 32'd1);
    cyc(1'b1, 8'h99, 1'b1, 1'b1, 1'b1);
    chk("rst_count", 32'(cnt1), 32'd0);
    chk("rst_empty", 32'(empty1), 32'd1);
    chk("rst_ovf", 32'(ovf1), 32'd0);
    chk("rst_dout_reg", 32'(dout0), 32'd0);
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("post_rst_fwft", 32'(dout1), 32'h3C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("post_rst_reg", 32'(dout0), 32'h3C);

    // Random traffic in write-heavy, balanced and read-heavy phases.
    for (int k = 0; k < 900; k++) begin
      int pw;
      pw = (k < 300) ? 75 : (k < 600) ? 50 : 25;
      cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < (100 - pw),
          $urandom_range(0, 15) == 0, $urandom_range(0, 127) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
